// File: rtl/omsp_bcd_seq.sv
// ----------------------------------------------------------------------------
// omsp_bcd_seq
//   Multi-cycle BCD add sequencer for the ALU DADD path. One 4-bit decimal
//   nibble adder is time-shared across a byte (2 nibbles) or a word
//   (NIB_MAX nibbles). It handles one nibble per clock, starting with the
//   LSB nibble, and ripples the decimal carry from nibble to nibble.
//
//   Optional feature macro: OMSP_BCD_SUB_EN
//     When defined, sub=1 selects ten's-complement subtraction (nine's
//     complement of each op_b nibble; cin=1 / cout=1 mean "no borrow").
//     When undefined, sub is ignored and the complement logic is not built.
//
// Ports
//   mclk       in   main clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   request pulse, sampled only in IDLE
//   byte_mode  in   1 = 8-bit (2 nibbles), 0 = 16-bit
//   sub        in   1 = BCD subtract (OMSP_BCD_SUB_EN builds only)
//   op_a       in   [15:0] first BCD operand
//   op_b       in   [15:0] second BCD operand
//   cin        in   carry in (for subtract: 1 = no borrow)
//   busy       out  high while nibbles are in progress
//   done       out  one-cycle pulse, result and flags valid
//   result     out  [15:0] BCD result, [15:8] = 0 in byte mode
//   cout       out  decimal carry out of the top nibble
//   zero       out  active-width result == 0
//   neg        out  result MSB (bit 7 byte / bit 15 word)
//
// States
//   state  | meaning
//   IDLE   | waiting for start; outputs hold their last values
//   RUN    | one nibble added per cycle, LSB nibble first
//   DONE   | single cycle; done=1, result and flags valid
// ----------------------------------------------------------------------------
module omsp_bcd_seq #(
    parameter int NIB_MAX = 4
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_mode,
    input  logic        sub,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        cin,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    output logic        zero,
    output logic        neg
);

    localparam int CW = (NIB_MAX > 1) ? $clog2(NIB_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [15:0]     r_op_a;
    logic [15:0]     r_op_b;
    logic            r_byte;
    logic            r_carry;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_result;
    logic            r_cout;
    logic            r_zero;
    logic            r_neg;

    logic            w_start_acc;
    logic            w_last;
    logic [CW+1:0]   w_sh;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_b_eff;
    logic [4:0]      w_sum;
    logic            w_gt9;
    logic [3:0]      w_digit;
    logic [15:0]     w_res_nxt;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_last      = r_byte ? (r_cnt == CW'(1)) : (r_cnt == CW'(NIB_MAX - 1));

    // Bit offset of the current nibble.
    assign w_sh    = {r_cnt, 2'b00};
    assign w_a_nib = r_op_a[w_sh +: 4];
    assign w_b_nib = r_op_b[w_sh +: 4];

`ifdef OMSP_BCD_SUB_EN
    logic r_sub;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sub <= 1'b0;
        end else if (w_start_acc) begin
            r_sub <= sub;
        end
    end

    // Nine's complement; non-BCD digits simply wrap, matching the
    // "no trapping" treatment of A-F on the add side.
    assign w_b_eff = r_sub ? (4'd9 - w_b_nib) : w_b_nib;
`else
    logic w_unused_sub;
    assign w_unused_sub = sub;
    assign w_b_eff      = w_b_nib;
`endif

    assign w_sum   = {1'b0, w_a_nib} + {1'b0, w_b_eff} + {4'b0000, r_carry};
    assign w_gt9   = (w_sum > 5'd9);
    // Low 4 bits of (s + 6) equal s[3:0] + 6 modulo 16.
    assign w_digit = w_gt9 ? (w_sum[3:0] + 4'd6) : w_sum[3:0];

    always_comb begin
        w_res_nxt = r_result;
        w_res_nxt[w_sh +: 4] = w_digit;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a   <= 16'h0000;
            r_op_b   <= 16'h0000;
            r_byte   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= 16'h0000;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
        end else if (w_start_acc) begin
            r_op_a   <= op_a;
            r_op_b   <= op_b;
            r_byte   <= byte_mode;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_result <= 16'h0000;
        end else if (r_state == S_RUN) begin
            r_result <= w_res_nxt;
            r_carry  <= w_gt9;
            r_cnt    <= r_cnt + CW'(1);
            // Flags are taken from the completed result so they are valid
            // together with done.
            if (w_last) begin
                r_cout <= w_gt9;
                r_zero <= r_byte ? (w_res_nxt[7:0] == 8'h00) : (w_res_nxt == 16'h0000);
                r_neg  <= r_byte ? w_res_nxt[7] : w_res_nxt[15];
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;
    assign neg    = r_neg;

endmodule

// File: tb/tb_omsp_bcd_seq.sv
module tb_omsp_bcd_seq;

    logic        mclk;
    logic        reset_n;
    logic        start;
    logic        byte_mode;
    logic        sub;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        neg;

    int n_vec  = 0;
    int n_miss = 0;

    omsp_bcd_seq #(.NIB_MAX(4)) u_dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .start     (start),
        .byte_mode (byte_mode),
        .sub       (sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Issue one operation, wait for done, check latency, busy window,
    // result, flags and the single-cycle done pulse.
    task automatic run_op(input string tag,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic bm, input logic sb,
                          input logic [15:0] exp_res, input logic exp_cout,
                          input logic exp_zero, input logic exp_neg,
                          input int exp_lat);
        int  cyc;
        bit  busy_ok;
        op_a      = a;
        op_b      = b;
        cin       = c;
        byte_mode = bm;
        sub       = sb;
        start     = 1'b1;
        tick();
        start   = 1'b0;
        op_a    = 16'hFFFF;
        op_b    = 16'hFFFF;
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 20) begin
            if (!busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check_eq({tag, " latency"}, cyc, exp_lat);
        check_eq({tag, " busy_window"}, {31'd0, busy_ok}, 32'd1);
        check_eq({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " result"}, {16'd0, result}, {16'd0, exp_res});
        check_eq({tag, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
        check_eq({tag, " zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check_eq({tag, " neg"}, {31'd0, neg}, {31'd0, exp_neg});
        tick();
        check_eq({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check_eq({tag, " result_hold"}, {16'd0, result}, {16'd0, exp_res});
    endtask

    initial begin
        int n_done;
        reset_n   = 1'b0;
        start     = 1'b0;
        byte_mode = 1'b0;
        sub       = 1'b0;
        op_a      = 16'h0000;
        op_b      = 16'h0000;
        cin       = 1'b0;
        #3;
        check_eq("rst busy",   {31'd0, busy},   32'd0);
        check_eq("rst done",   {31'd0, done},   32'd0);
        check_eq("rst result", {16'd0, result}, 32'd0);
        check_eq("rst flags",  {29'd0, cout, zero, neg}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        //     tag          op_a      op_b      cin   byte  sub   result    cout  zero  neg   lat
        run_op("word_add",  16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
        run_op("word_ovf",  16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 5);
        run_op("byte_add",  16'hAB58, 16'hCD47, 1'b0, 1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b0, 3);
        run_op("bad_digit", 16'h000F, 16'h000F, 1'b1, 1'b0, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 5);
        run_op("word_neg",  16'h5000, 16'h4000, 1'b0, 1'b0, 1'b0, 16'h9000, 1'b0, 1'b0, 1'b1, 5);
        run_op("byte_neg",  16'h1245, 16'h3445, 1'b0, 1'b1, 1'b0, 16'h0090, 1'b0, 1'b0, 1'b1, 3);
        run_op("byte_zero", 16'h0050, 16'h0050, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3);
        run_op("word_cin",  16'h0999, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 5);
`ifdef OMSP_BCD_SUB_EN
        run_op("sub_nb",    16'h0100, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, 1'b0, 5);
        run_op("sub_brw",   16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1, 5);
`else
        run_op("sub_off",   16'h0100, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0, 5);
`endif

        // Second start while running must be ignored.
        op_a = 16'h1234; op_b = 16'h5678; cin = 1'b0; byte_mode = 1'b0; sub = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op_a = 16'h1111; op_b = 16'h1111; cin = 1'b1; byte_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) begin
                n_done++;
                check_eq("ignore result", {16'd0, result}, 32'h0000_6912);
            end
            tick();
        end
        check_eq("ignore done_count", n_done, 1);

        // Reset in cycle 2 of a word op.
        op_a = 16'h1234; op_b = 16'h5678; cin = 1'b0; byte_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check_eq("midrst busy",   {31'd0, busy},   32'd0);
        check_eq("midrst result", {16'd0, result}, 32'd0);
        check_eq("midrst flags",  {28'd0, done, cout, zero, neg}, 32'd0);
        tick();
        reset_n = 1'b1;
        n_done  = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n_done++;
            tick();
        end
        check_eq("midrst no_done", n_done, 0);
        run_op("after_rst", 16'h4321, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/omsp_bcd_seq.md
Name: omsp_bcd_seq

Overview:
- Multi-cycle BCD (decimal) add sequencer for the ALU's DADD path.
- Time-shares one 4-bit nibble BCD adder across a byte (2 nibbles) or word (4 nibbles), one nibble per clock, LSB nibble first, rippling the decimal carry.
- Accepts a start pulse from the execution unit and returns a result, flags and a one-cycle done pulse.

Parameters:
- NIB_MAX, 4, nibbles per word operation; byte mode always uses 2.

Ports:
- mclk  in  1  main clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- byte_mode  in  1  1 = 8-bit operation (2 nibbles); 0 = 16-bit operation
- sub  in  1  1 = BCD subtract (only with OMSP_BCD_SUB_EN)
- op_a  in  16  first operand (BCD)
- op_b  in  16  second operand (BCD)
- cin  in  1  carry in (C flag); for subtract, 1 = no borrow
- busy  out  1  high while nibbles are in progress
- done  out  1  one-cycle pulse; result and flags are valid
- result  out  16  BCD result; bits 15:8 are 0 in byte mode
- cout  out  1  decimal carry out of the top nibble
- zero  out  1  active-width result == 0
- neg  out  1  result MSB (bit 7 in byte mode, bit 15 in word mode)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; busy, done, result, cout, zero and neg all 0; nibble counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch op_a, op_b, cin, byte_mode and sub; set the carry register to cin; set the counter to 0; go to RUN; busy=1 from the next cycle.
- IDLE, start=0: remain in IDLE.
- RUN, each cycle, for nibble k:
  - b' = op_b nibble k, or 9 - op_b nibble k when subtracting.
  - s = a_k + b' + carry, 5-bit.
  - If s > 9: digit = (s + 6)[3:0], carry = 1. Otherwise digit = s[3:0], carry = 0.
  - Write the digit to result[4k+3:4k]; increment the counter.
- RUN, last nibble (k = 1 in byte mode, NIB_MAX-1 in word mode): go to DONE.
- DONE, one cycle: done=1, busy=0. cout = final carry; zero and neg are computed over the active width. Then return to IDLE.
- Latency: start sampled in cycle 0 → done in cycle 3 (byte) or cycle 5 (word). Back-to-back start is accepted in the cycle after done.
- Outputs hold their last values until the next accepted start. Result is cleared to 0 on start acceptance.
- start while busy or in DONE: ignored, with no effect on the operation in flight.
- Operand inputs may change after start acceptance; only the latched copies are used.
- Non-BCD digits (A–F) are not trapped. They follow the s>9 rule exactly (e.g. F+F+1 → digit 5, carry 1).
- reset_n asserted mid-operation: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: OMSP_BCD_SUB_EN.
- Defined: sub=1 selects ten's-complement subtraction. Each op_b nibble is replaced by its nine's complement; cin=1 means no borrow; cout=1 means no borrow out.
- Undefined: the sub input is ignored (treated as 0) and the complement logic is not synthesized; add behaviour is unchanged.

Test Plan:
- Word add: op_a=0x1234, op_b=0x5678, cin=0, start → done exactly 5 cycles later; result=0x6912, cout=0, zero=0, neg=0; busy high for cycles 1–4.
- Word overflow: 0x9999 + 0x0001, cin=0 → result=0x0000, cout=1, zero=1.
- Byte mode: op_a=0xAB58, op_b=0xCD47, cin=0 → done at cycle 3; result=0x0005, cout=1, zero=0, neg=0.
- Invalid digit: 0x000F + 0x000F, cin=1 → result=0x0015, cout=0.
- Control: a second start during RUN is ignored (single done, result from the first operands). reset_n pulsed low at cycle 2 of a word op → all outputs 0 at once, no done; a new start afterwards completes normally.
- OMSP_BCD_SUB_EN: 0x0100 - 0x0001, cin=1 → 0x0099, cout=1. 0x0000 - 0x0001, cin=1 → 0x9999, cout=0. Without the macro, sub=1 with 0x0100/0x0001, cin=0 → 0x0101 (plain add).
